// File: rtl/uart_tx_serializer_if.sv
// Byte-load and serial-status bundle between the UART control FSM (master)
// and the transmit serializer (slave).
interface uart_tx_serializer_if;
  logic       ld_tx_data;   // 1-cycle strobe: push tx_data into the FIFO
  logic [7:0] tx_data;      // byte to send, sampled with ld_tx_data
  logic       tx_enable;    // level; any high cycle arms transmission
  logic       tx_out;       // serial line, idles high
  logic       tx_empty;     // FIFO empty and no frame in flight
  logic       tx_full;      // FIFO holds FIFO_DEPTH bytes
  logic       tx_overrun;   // sticky: push arrived while full

  modport master (
    output ld_tx_data, tx_data, tx_enable,
    input  tx_out, tx_empty, tx_full, tx_overrun
  );

  modport slave (
    input  ld_tx_data, tx_data, tx_enable,
    output tx_out, tx_empty, tx_full, tx_overrun
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1 UART transmitter.
// Bytes strobed in by the upstream controller queue in a small FIFO; once
// tx_enable has armed the block, the FIFO drains back-to-back onto tx_out.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD selects odd/even).
module uart_tx_serializer #(
  parameter int CLK_DIV    = 434,  // clock cycles per UART bit, >= 2
  parameter int FIFO_DEPTH = 4,    // byte entries, power of 2, >= 2
  parameter int PARITY_ODD = 0     // parity build only: 0 = even, 1 = odd
) (
  input  logic                   clock_i,
  input  logic                   reset_i,   // synchronous, active-high
  uart_tx_serializer_if.slave    bus_io
);

  localparam int AW = $clog2(FIFO_DEPTH);   // FIFO address width
  localparam int PW = AW + 1;               // pointer width incl. wrap bit
  localparam int BW = $clog2(CLK_DIV);      // baud counter width
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  // Elaboration-time parameter sanity checks.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_serializer: CLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_serializer: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          tx_full_q, tx_empty_q, tx_overrun_q;
  logic          armed_q, armed_d;

  state_e        state_q;
  logic [BW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_out_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // ---------------------------------------------------------------------
  // FIFO status and transfer decisions (all from registered state)
  // ---------------------------------------------------------------------
  logic       fifo_empty, fifo_full;
  logic       baud_last;
  logic       push, pop;
  logic [7:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign baud_last  = (baud_cnt_q == BAUD_LAST);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness is judged before any same-cycle pop, so a push on full is
  // always dropped.
  assign push = bus_io.ld_tx_data && !fifo_full;

  // A new frame starts from IDLE (armed, or armed this very cycle) or
  // directly at the end of a stop bit (armed only) so bursts leave no gap.
  assign pop = !fifo_empty &&
               (((state_q == IDLE) && (armed_q || bus_io.tx_enable)) ||
                ((state_q == STOP) && baud_last && armed_q));

  // Next-state for FIFO pointers and the armed flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    armed_d  = armed_q || bus_io.tx_enable;
    // Disarm only when a frame ends with nothing left to send.
    if ((state_q == STOP) && baud_last && fifo_empty && !bus_io.tx_enable) begin
      armed_d = 1'b0;
    end
  end

  // FIFO pointers, status flags and the armed flag.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tx_full_q    <= 1'b0;
      tx_empty_q   <= 1'b1;
      tx_overrun_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tx_full_q    <= (wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}};
      tx_empty_q   <= fifo_empty && (state_q == IDLE);
      armed_q      <= armed_d;
      if (bus_io.ld_tx_data && fifo_full) begin
        tx_overrun_q <= 1'b1;
      end
    end
  end

  // FIFO data array write port.
  always_ff @(posedge clock_i) begin
    // NOTE: the byte array is deliberately not reset; the pointers alone
    // decide which entries are valid.
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus_io.tx_data;
    end
  end

  // Frame sequencer: START, 8 data bits LSB first, [PARITY], STOP.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_out_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_out_q <= 1'b1;
          if (pop) begin
            shift_q    <= head;
            baud_cnt_q <= '0;
            tx_out_q   <= 1'b0;
            state_q    <= START;
`ifdef UART_TX_PARITY_EN
            parity_q   <= (^head) ^ PARITY_ODD[0];
`endif
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_out_q   <= shift_q[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_out_q <= parity_q;
              state_q  <= PARITY;
`else
              tx_out_q <= 1'b1;
              state_q  <= STOP;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_out_q  <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            tx_out_q   <= 1'b1;
            state_q    <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end
`endif

        STOP: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q  <= head;
              tx_out_q <= 1'b0;
              state_q  <= START;
`ifdef UART_TX_PARITY_EN
              parity_q <= (^head) ^ PARITY_ODD[0];
`endif
            end else begin
              tx_out_q <= 1'b1;
              state_q  <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BW'(1);
          end
        end

        default: begin
          tx_out_q <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.tx_out     = tx_out_q;
  assign bus_io.tx_empty   = tx_empty_q;
  assign bus_io.tx_full    = tx_full_q;
  assign bus_io.tx_overrun = tx_overrun_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: directed scenarios plus random traffic,
// with a queue-based line model compared against the DUT on every cycle.
module tb_uart_tx_serializer;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if bus ();

  uart_tx_serializer #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH),
    .PARITY_ODD(0)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial bit sequence of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // ---------------------------------------------------------------------
  // Behavioural model: byte queue, armed flag, and the waveform still owed
  // on the line for the frame in flight.
  // ---------------------------------------------------------------------
  logic [7:0] q_m[$];
  bit         wave_m[$];
  bit         armed_m, in_frame_m, ov_m, model_valid;
  bit         exp_line, exp_empty, exp_full;

  always @(posedge clk) begin : model
    int         pre_n;
    bit         pre_frame, go, clr;
    logic [7:0] b;
    logic [10:0] f;
    if (rst) begin
      q_m.delete();
      wave_m.delete();
      armed_m = 0; in_frame_m = 0; ov_m = 0;
      exp_line = 1; exp_empty = 1; exp_full = 0;
      model_valid = 1;
    end else begin
      pre_n     = q_m.size();
      pre_frame = in_frame_m;
      clr       = 0;
      exp_empty = (pre_n == 0) && !pre_frame;
      if (wave_m.size() > 0) begin
        exp_line = wave_m.pop_front();
      end else begin
        go = (pre_n > 0) && (pre_frame ? armed_m : (armed_m || bus.tx_enable));
        if (go) begin
          b = q_m.pop_front();
          f = frame_of(b);
          for (int i = 0; i < NBITS; i++)
            for (int k = 0; k < CLK_DIV; k++) wave_m.push_back(f[i]);
          exp_line   = wave_m.pop_front();
          in_frame_m = 1;
        end else begin
          exp_line = 1;
          if (pre_frame && pre_n == 0 && !bus.tx_enable) clr = 1;
          in_frame_m = 0;
        end
      end
      armed_m = clr ? 1'b0 : (armed_m || bus.tx_enable);
      if (bus.ld_tx_data) begin
        if (pre_n == DEPTH) ov_m = 1;
        else q_m.push_back(bus.tx_data);
      end
      exp_full = (q_m.size() == DEPTH);
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("tx_out",     bus.tx_out,     exp_line);
      check("tx_empty",   bus.tx_empty,   exp_empty);
      check("tx_full",    bus.tx_full,    exp_full);
      check("tx_overrun", bus.tx_overrun, ov_m);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  logic        cap [200];
  logic [10:0] fr;

  initial begin
    bus.ld_tx_data = 0;
    bus.tx_data    = '0;
    bus.tx_enable  = 0;
    rst = 1;
    tick(2);
    rst = 0;

    // 1: idle after reset
    tick(20);
    check("t1_tx_out", bus.tx_out, 1'b1);
    check("t1_empty",  bus.tx_empty, 1'b1);
    check("t1_full",   bus.tx_full, 1'b0);
    check("t1_ovr",    bus.tx_overrun, 1'b0);

    // 2: single 0xA5 frame, pinned against a literal bit pattern
    bus.ld_tx_data = 1; bus.tx_data = 8'hA5; bus.tx_enable = 1;
    tick(1);
    bus.ld_tx_data = 0; bus.tx_enable = 0;
    for (int i = 0; i < FLEN; i++) begin
      tick(1);
      cap[i] = bus.tx_out;
    end
`ifdef UART_TX_PARITY_EN
    fr = 11'b1_0_10100101_0;
`else
    fr = 11'b11_10100101_0;
`endif
    for (int i = 0; i < FLEN; i++) check("t2_bit", cap[i], fr[i / CLK_DIV]);
    tick(1);
    check("t2_idle_line", bus.tx_out, 1'b1);
    check("t2_empty_lag", bus.tx_empty, 1'b0);
    tick(1);
    check("t2_empty", bus.tx_empty, 1'b1);

    // 3: three-byte burst, back-to-back frames
    for (int i = 0; i < 3 * FLEN + 5; i++) begin
      case (i)
        0: begin bus.ld_tx_data = 1; bus.tx_data = 8'h12; bus.tx_enable = 1; end
        1: bus.tx_data = 8'h34;
        2: bus.tx_data = 8'h56;
        3: bus.ld_tx_data = 0;
        10: bus.tx_enable = 0;
        default: ;
      endcase
      tick(1);
      cap[i] = bus.tx_out;
    end
    for (int k = 0; k < 3; k++) begin
      fr = frame_of(k == 0 ? 8'h12 : (k == 1 ? 8'h34 : 8'h56));
      for (int j = 0; j < NBITS; j++)
        check("t3_bit", cap[1 + k * FLEN + j * CLK_DIV + 1], fr[j]);
    end
    check("t3_gap1", cap[1 + FLEN], 1'b0);
    check("t3_gap2", cap[1 + 2 * FLEN], 1'b0);
    check("t3_after", cap[1 + 3 * FLEN], 1'b1);
    check("t3_ovr", bus.tx_overrun, 1'b0);

    // 4: overfill without tx_enable, then drain
    for (int i = 0; i < 6; i++) begin
      bus.ld_tx_data = 1; bus.tx_data = 8'(($urandom));
      tick(1);
      if (i == 2) check("t4_not_full", bus.tx_full, 1'b0);
      if (i == 3) check("t4_full", bus.tx_full, 1'b1);
    end
    bus.ld_tx_data = 0;
    check("t4_ovr", bus.tx_overrun, 1'b1);
    tick(20);
    check("t4_held", bus.tx_out, 1'b1);
    bus.tx_enable = 1;
    tick(1);
    bus.tx_enable = 0;
    tick(4 * FLEN + 10);
    check("t4_empty", bus.tx_empty, 1'b1);
    check("t4_full_clr", bus.tx_full, 1'b0);
    check("t4_ovr_sticky", bus.tx_overrun, 1'b1);

    // 5: reset in the middle of a 0xFF frame
    bus.ld_tx_data = 1; bus.tx_data = 8'hFF; bus.tx_enable = 1;
    tick(1);
    bus.ld_tx_data = 0; bus.tx_enable = 0;
    tick(15);
    rst = 1;
    tick(1);
    rst = 0;
    check("t5_line", bus.tx_out, 1'b1);
    check("t5_empty", bus.tx_empty, 1'b1);
    check("t5_ovr", bus.tx_overrun, 1'b0);
    tick(2 * FLEN);
    check("t5_quiet", bus.tx_out, 1'b1);

`ifdef UART_TX_PARITY_EN
    // 6: parity bit values, 44-cycle frames
    for (int k = 0; k < 2; k++) begin
      bus.ld_tx_data = 1; bus.tx_data = (k == 0) ? 8'h07 : 8'h03; bus.tx_enable = 1;
      tick(1);
      bus.ld_tx_data = 0; bus.tx_enable = 0;
      for (int i = 0; i < FLEN + 2; i++) begin
        tick(1);
        cap[i] = bus.tx_out;
      end
      check("t6_parity", cap[9 * CLK_DIV + 1], (k == 0) ? 1'b1 : 1'b0);
      check("t6_stop", cap[FLEN - 1], 1'b1);
      check("t6_len_start", cap[0], 1'b0);
      check("t6_empty", bus.tx_empty, 1'b1);
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.ld_tx_data = ($urandom_range(0, 9) < 3);
      bus.tx_data    = 8'($urandom);
      bus.tx_enable  = ($urandom_range(0, 9) < 2);
      rst            = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    bus.ld_tx_data = 0; rst = 0; bus.tx_enable = 1;
    tick(1);
    bus.tx_enable = 0;
    tick((DEPTH + 2) * FLEN);
    check("rand_drained", bus.tx_empty, 1'b1);
    check("rand_line", bus.tx_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
